// File: rtl/pipeline_hazard_ctrl_pkg.sv
// pipeline_hazard_ctrl_pkg: shared types and constants for the hazard controller
package pipeline_hazard_ctrl_pkg;
  localparam int REG_ADDR_W = 5;
  localparam int DEF_MUL_LAT = 3;
  localparam logic [REG_ADDR_W-1:0] X0 = '0;
  typedef enum logic {
    RUN      = 1'b0,
    MUL_WAIT = 1'b1
  } state_e;
endpackage

// File: rtl/pipeline_hazard_ctrl_hazard_match.sv
// pipeline_hazard_ctrl_hazard_match: load-use detector, decode sources vs EX load destination
module pipeline_hazard_ctrl_hazard_match
  import pipeline_hazard_ctrl_pkg::*;
(
  input  logic [REG_ADDR_W-1:0] rs1_i,
  input  logic [REG_ADDR_W-1:0] rs2_i,
  input  logic                  use_rs1_i,
  input  logic                  use_rs2_i,
  input  logic [REG_ADDR_W-1:0] rd_i,
  input  logic                  load_i,
  output logic                  ldu_o
);
  logic hit1, hit2;
  // x0 is never a real producer, so a load targeting it cannot create a hazard
  always_comb begin
    hit1  = use_rs1_i && rs1_i == rd_i;
    hit2  = use_rs2_i && rs2_i == rd_i;
    ldu_o = load_i && rd_i != X0 && (hit1 || hit2);
  end
endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: stall/flush scheduler for the 5-stage pipeline; HAZ_PERF_CNT_EN adds stall_cnt/flush_cnt
module pipeline_hazard_ctrl
  import pipeline_hazard_ctrl_pkg::*;
#(
  parameter int MUL_LAT = DEF_MUL_LAT
`ifdef HAZ_PERF_CNT_EN
  ,
  parameter int CNT_W = 32
`endif
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic                  id_use_rs1,
  input  logic                  id_use_rs2,
  input  logic [REG_ADDR_W-1:0] ex_rd,
  input  logic                  ex_mem_read,
  input  logic                  ex_is_mul,
  input  logic                  mem_redirect,
  output logic                  pc_en,
  output logic                  if_id_en,
  output logic                  id_ex_en,
  output logic                  ex_mem_en,
  output logic                  if_id_flush,
  output logic                  id_ex_bubble,
  output logic                  ex_mem_bubble,
  output logic                  mul_busy
`ifdef HAZ_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0]      stall_cnt,
  output logic [CNT_W-1:0]      flush_cnt
`endif
);
  localparam int CW = MUL_LAT > 2 ? $clog2(MUL_LAT - 1) : 1;
  localparam int LOAD = MUL_LAT > 1 ? MUL_LAT - 2 : 0;
  localparam logic MUL_STALLS = MUL_LAT > 1;
  state_e state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic ldu, run, mul_stall;
  pipeline_hazard_ctrl_hazard_match u_match (
    .rs1_i     (id_rs1),
    .rs2_i     (id_rs2),
    .use_rs1_i (id_use_rs1),
    .use_rs2_i (id_use_rs2),
    .rd_i      (ex_rd),
    .load_i    (ex_mem_read),
    .ldu_o     (ldu)
  );
  // state and remaining-stall counter; frozen while the pipeline is disabled
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RUN;
      cnt_q   <= '0;
    end else if (enable) begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end
  // redirect beats multiply stall, multiply stall beats load-use; cnt_q counts stall cycles still owed after this one
  always_comb begin
    run = !rst && enable;
    mul_stall = (state_q == RUN && ex_is_mul && MUL_STALLS) || (state_q == MUL_WAIT && cnt_q != '0);
    state_d = state_q;
    cnt_d = cnt_q;
    pc_en = 1'b0;
    if_id_en = 1'b0;
    id_ex_en = 1'b0;
    ex_mem_en = 1'b0;
    if_id_flush = 1'b0;
    id_ex_bubble = 1'b0;
    ex_mem_bubble = 1'b0;
    mul_busy = 1'b0;
    if (run && mem_redirect) begin
      {pc_en, if_id_en, id_ex_en, ex_mem_en} = 4'b1111;
      {if_id_flush, id_ex_bubble, ex_mem_bubble} = 3'b111;
      state_d = RUN;
      cnt_d = '0;
    end else if (run && mul_stall) begin
      ex_mem_en = 1'b1;
      ex_mem_bubble = 1'b1;
      mul_busy = 1'b1;
      state_d = MUL_WAIT;
      cnt_d = state_q == RUN ? CW'(LOAD) : cnt_q - CW'(1);
    end else if (run) begin
      pc_en = !ldu;
      if_id_en = !ldu;
      id_ex_en = 1'b1;
      ex_mem_en = 1'b1;
      id_ex_bubble = ldu;
      state_d = RUN;
      cnt_d = '0;
    end
  end
`ifdef HAZ_PERF_CNT_EN
  logic [CNT_W-1:0] stall_q, flush_q;
  // free-running wrap-around event counters for stalled and redirected cycles
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_q <= '0;
      flush_q <= '0;
    end else if (enable) begin
      stall_q <= pc_en ? stall_q : stall_q + CNT_W'(1);
      flush_q <= mem_redirect ? flush_q + CNT_W'(1) : flush_q;
    end
  end
  assign stall_cnt = stall_q;
  assign flush_cnt = flush_q;
`endif
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb_pipeline_hazard_ctrl: directed bench comparing MUL_LAT=3 and MUL_LAT=1 instances against a behavioural model
module tb_pipeline_hazard_ctrl;
  localparam logic [7:0] Z = 8'b0000_0000;
  localparam logic [7:0] N = 8'b1111_0000;
  localparam logic [7:0] L = 8'b0011_0100;
  localparam logic [7:0] M = 8'b0001_0011;
  localparam logic [7:0] R = 8'b1111_1110;
  logic clk = 1'b0;
  logic rst = 1'b1, en = 1'b1, ur1 = 1'b0, ur2 = 1'b0, ld = 1'b0, mul = 1'b0, redir = 1'b0;
  logic [4:0] rs1 = '0, rs2 = '0, rd = '0;
  logic [7:0] o3, o1;
  logic lit_on = 1'b0, perf_on = 1'b0;
  logic [7:0] lit3 = '0, lit1 = '0;
  int left3 = 0, left1 = 0;
  int tests = 0, fails = 0;
`ifdef HAZ_PERF_CNT_EN
  logic [31:0] sc3, fc3, sc1, fc1;
  logic [31:0] ms3 = '0, mf3 = '0, ms1 = '0, mf1 = '0;
`endif
  always #5 clk = ~clk;
  pipeline_hazard_ctrl #(.MUL_LAT(3)) u3 (
    .clk(clk), .rst(rst), .enable(en), .id_rs1(rs1), .id_rs2(rs2), .id_use_rs1(ur1), .id_use_rs2(ur2),
    .ex_rd(rd), .ex_mem_read(ld), .ex_is_mul(mul), .mem_redirect(redir),
    .pc_en(o3[7]), .if_id_en(o3[6]), .id_ex_en(o3[5]), .ex_mem_en(o3[4]),
    .if_id_flush(o3[3]), .id_ex_bubble(o3[2]), .ex_mem_bubble(o3[1]), .mul_busy(o3[0])
`ifdef HAZ_PERF_CNT_EN
    , .stall_cnt(sc3), .flush_cnt(fc3)
`endif
  );
  pipeline_hazard_ctrl #(.MUL_LAT(1)) u1 (
    .clk(clk), .rst(rst), .enable(en), .id_rs1(rs1), .id_rs2(rs2), .id_use_rs1(ur1), .id_use_rs2(ur2),
    .ex_rd(rd), .ex_mem_read(ld), .ex_is_mul(mul), .mem_redirect(redir),
    .pc_en(o1[7]), .if_id_en(o1[6]), .id_ex_en(o1[5]), .ex_mem_en(o1[4]),
    .if_id_flush(o1[3]), .id_ex_bubble(o1[2]), .ex_mem_bubble(o1[1]), .mul_busy(o1[0])
`ifdef HAZ_PERF_CNT_EN
    , .stall_cnt(sc1), .flush_cnt(fc1)
`endif
  );
  // left = EX cycles the in-flight multiply still occupies, counting the current one
  function automatic void model(input int lat, input int left, output logic [7:0] o, output int nleft);
    bit hz;
    int occ;
    hz = ld && rd != 0 && ((ur1 && rs1 == rd) || (ur2 && rs2 == rd));
    occ = left > 0 ? left : (mul ? lat : 0);
    nleft = 0;
    if (rst) o = Z;
    else if (!en) begin
      o = Z;
      nleft = left;
    end else if (redir) o = R;
    else if (occ > 1) begin
      o = M;
      nleft = occ - 1;
    end else o = hz ? L : N;
  endfunction
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
    end
  endtask
  always @(posedge clk) begin
    logic [7:0] e3, e1;
    int n3, n1;
    model(3, left3, e3, n3);
    model(1, left1, e1, n1);
`ifdef HAZ_PERF_CNT_EN
    if (rst) begin
      ms3 = 0; mf3 = 0; ms1 = 0; mf1 = 0;
    end else if (en) begin
      if (!e3[7]) ms3++;
      if (!e1[7]) ms1++;
      if (redir) begin
        mf3++;
        mf1++;
      end
    end
`endif
    left3 = n3;
    left1 = n1;
  end
  always @(negedge clk) begin
    logic [7:0] e3, e1;
    int n3, n1;
    model(3, left3, e3, n3);
    model(1, left1, e1, n1);
    chk("outs_lat3", {24'd0, o3}, {24'd0, e3});
    chk("outs_lat1", {24'd0, o1}, {24'd0, e1});
    if (lit_on) begin
      chk("lit_dut_lat3", {24'd0, o3}, {24'd0, lit3});
      chk("lit_dut_lat1", {24'd0, o1}, {24'd0, lit1});
      chk("lit_model_lat3", {24'd0, e3}, {24'd0, lit3});
      chk("lit_model_lat1", {24'd0, e1}, {24'd0, lit1});
    end
`ifdef HAZ_PERF_CNT_EN
    chk("stall_cnt_lat3", sc3, ms3);
    chk("flush_cnt_lat3", fc3, mf3);
    chk("stall_cnt_lat1", sc1, ms1);
    chk("flush_cnt_lat1", fc1, mf1);
    if (perf_on) begin
      chk("stall_cnt_lit", sc3, 32'd2);
      chk("flush_cnt_lit", fc3, 32'd1);
      chk("stall_model_lit", ms3, 32'd2);
    end
`endif
  end
  task automatic st(input logic r, e, input logic [4:0] a, b, input logic ua, ub, input logic [4:0] d,
                    input logic l, m, x, input logic [7:0] x3, x1);
    rst = r; en = e; rs1 = a; rs2 = b; ur1 = ua; ur2 = ub; rd = d; ld = l; mul = m; redir = x;
    lit_on = 1'b1; lit3 = x3; lit1 = x1;
    @(posedge clk);
    #1;
  endtask
  initial begin
    @(posedge clk);
    #1;
    st(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, Z, Z);
    st(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, N, N);
    st(0, 1, 5, 0, 1, 0, 5, 1, 0, 0, L, L);
    st(0, 1, 5, 0, 1, 0, 9, 0, 0, 0, N, N);
    st(0, 1, 0, 0, 1, 0, 0, 1, 0, 0, N, N);
    st(0, 1, 3, 6, 1, 0, 6, 1, 0, 0, N, N);
    st(0, 1, 3, 6, 1, 1, 6, 1, 0, 0, L, L);
    for (int i = 0; i < 2; i++) st(0, 1, 0, 0, 0, 0, 0, 0, 1, 0, M, N);
    st(0, 1, 0, 0, 0, 0, 0, 0, 1, 0, N, N);
    st(0, 1, 0, 0, 0, 0, 0, 0, 1, 0, M, N);
    st(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, M, N);
    st(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, N, N);
    st(0, 1, 0, 0, 0, 0, 0, 0, 1, 0, M, N);
    st(0, 1, 0, 0, 0, 0, 0, 0, 1, 1, R, R);
    st(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, N, N);
    st(0, 1, 0, 0, 0, 0, 0, 0, 1, 0, M, N);
    st(0, 1, 0, 0, 0, 0, 0, 0, 1, 0, M, N);
    st(0, 1, 7, 0, 1, 0, 7, 1, 1, 0, L, L);
    st(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, N, N);
    st(0, 1, 0, 0, 0, 0, 0, 0, 1, 0, M, N);
    for (int i = 0; i < 4; i++) st(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, Z, Z);
    st(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, M, N);
    st(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, N, N);
    st(0, 1, 0, 0, 0, 0, 0, 0, 1, 0, M, N);
    st(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, Z, Z);
    st(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, N, N);
    st(0, 1, 4, 0, 1, 0, 4, 1, 0, 0, L, L);
    st(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, N, N);
    st(0, 1, 0, 8, 0, 1, 8, 1, 0, 0, L, L);
    st(0, 1, 0, 0, 0, 0, 0, 0, 0, 1, R, R);
    perf_on = 1'b1;
    st(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, N, N);
    perf_on = 1'b0;
    lit_on = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
